// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and constants for the FIFO burst reader.
// Holds the controller state encoding and the skid buffer geometry.
// Imported by fifo_burst_reader and rd_skid_buf.
package fifo_burst_reader_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Two entries cover the one-cycle FIFO read latency plus one stalled beat.
    localparam int SKID_DEPTH = 2;
    localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry skid buffer between the FIFO read port and the downstream beat port.
// Latency: one cycle from input handshake to output valid.
// Backpressure: i_out_rdy low holds the head entry; o_in_rdy drops when both entries are full.
module rd_skid_buf
    import fifo_burst_reader_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_in_vld,
    output logic                  o_in_rdy,
    input  logic [WIDTH-1:0]      i_in_dat,
    output logic                  o_out_vld,
    input  logic                  i_out_rdy,
    output logic [WIDTH-1:0]      o_out_dat,
    output logic [SKID_CNT_W-1:0] o_count
);

    logic [WIDTH-1:0]      r_mem [0:SKID_DEPTH-1];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [SKID_CNT_W-1:0] r_cnt;

    logic w_push;
    logic w_pop;

    assign o_in_rdy  = (r_cnt != SKID_CNT_W'(SKID_DEPTH));
    assign o_out_vld = (r_cnt != '0);
    // Head entry is driven straight from storage so it cannot move while stalled.
    assign o_out_dat = o_out_vld ? r_mem[r_rd_ptr] : '0;
    assign o_count   = r_cnt;

    assign w_push = i_in_vld && o_in_rdy;
    assign w_pop  = o_out_vld && i_out_rdy;

    // Ring storage, pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_in_dat;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + SKID_CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - SKID_CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Pops fixed-length bursts from a synch_fifo and presents them as valid/ready beats with out_last.
// Latency: two cycles from the first pop to the first out_valid; one beat per cycle with out_ready high.
// Backpressure: out_ready low stalls beats in the skid buffer and throttles pops to keep it from overflowing.
// Optional macro FIFO_BURST_READER_TIMEOUT_EN flushes a partial burst after TIMEOUT idle cycles.
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int FIFO_PTR   = 4,
    parameter int FIFO_WIDTH = 32,
    parameter int BURST_LEN  = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [FIFO_PTR:0]     fifo_data_avail,
    input  logic [FIFO_WIDTH-1:0] fifo_read_data,
    output logic                  fifo_read_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FIFO_WIDTH-1:0] out_data,
    output logic                  out_last
);

    localparam int               CNT_W        = FIFO_PTR + 1;
    localparam logic [CNT_W-1:0] LP_BURST_LEN = CNT_W'(BURST_LEN);

    if (BURST_LEN < 1 || BURST_LEN > (1 << FIFO_PTR) || TIMEOUT < 1) begin : g_param_check
        $error("fifo_burst_reader: BURST_LEN must be 1..2**FIFO_PTR and TIMEOUT at least 1");
    end

    state_t           r_state;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_issue;
    logic [CNT_W-1:0] r_beat;
    logic             r_inflight;

    logic                  w_skid_vld;
    logic [FIFO_WIDTH-1:0] w_skid_dat;
    logic [SKID_CNT_W-1:0] w_skid_cnt;
    logic                  w_skid_in_rdy;
    logic                  w_skid_push;
    logic                  w_out_hs;
    logic [2:0]            w_occ;
    logic                  w_rd_en;
    logic                  w_last_beat;
    logic                  w_tmo_fire;

    assign w_out_hs    = w_skid_vld && out_ready;
    // Entries held plus the read still in flight, less whatever leaves this cycle.
    assign w_occ       = {1'b0, w_skid_cnt} + {2'b00, r_inflight} - {2'b00, w_out_hs};
    assign w_rd_en     = (r_state == BURST) && !fifo_empty && (r_issue < r_len)
                         && (w_occ < 3'(SKID_DEPTH));
    assign w_last_beat = (r_beat == (r_len - CNT_W'(1)));
    // The occupancy rule already guarantees room; the gate only protects a full buffer.
    assign w_skid_push = r_inflight && w_skid_in_rdy;

    assign fifo_read_en = w_rd_en;
    assign out_valid    = w_skid_vld;
    assign out_data     = w_skid_dat;
    assign out_last     = w_skid_vld && w_last_beat;

    rd_skid_buf #(
        .WIDTH (FIFO_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .i_in_vld  (w_skid_push),
        .o_in_rdy  (w_skid_in_rdy),
        .i_in_dat  (fifo_read_data),
        .o_out_vld (w_skid_vld),
        .i_out_rdy (out_ready),
        .o_out_dat (w_skid_dat),
        .o_count   (w_skid_cnt)
    );

`ifdef FIFO_BURST_READER_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    logic [TMR_W-1:0] r_timer;
    logic             w_tmo_qual;

    // The timer only runs while a partial burst sits in the FIFO during IDLE.
    assign w_tmo_qual = (r_state == IDLE) && !fifo_empty && (fifo_data_avail < LP_BURST_LEN);
    assign w_tmo_fire = w_tmo_qual && (r_timer == TMR_W'(TIMEOUT - 1));

    // Idle timer: clears on empty, on any burst start, and on expiry.
    always_ff @(posedge clk) begin
        if (rst || !w_tmo_qual || w_tmo_fire) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + TMR_W'(1);
        end
    end
`else
    assign w_tmo_fire = 1'b0;
`endif

    // Burst controller: latch length on entry, count pops and beats, leave on the last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_len      <= '0;
            r_issue    <= '0;
            r_beat     <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            case (r_state)
                IDLE: begin
                    r_issue <= '0;
                    r_beat  <= '0;
                    if (fifo_data_avail >= LP_BURST_LEN) begin
                        r_state <= BURST;
                        r_len   <= LP_BURST_LEN;
                    end else if (w_tmo_fire) begin
                        r_state <= BURST;
                        r_len   <= fifo_data_avail;
                    end
                end
                BURST: begin
                    if (w_rd_en) begin
                        r_issue <= r_issue + CNT_W'(1);
                    end
                    if (w_out_hs) begin
                        r_beat <= r_beat + CNT_W'(1);
                        // Returning to IDLE forces at least one idle cycle between bursts.
                        if (w_last_beat) begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader with a behavioural synch_fifo and a beat scoreboard.
// Stimulus table drives full-burst scenarios; hand sequences cover timeout flush and mid-burst reset.
// Optional macro FIFO_BURST_READER_TIMEOUT_EN selects the flush expectation.
module tb_fifo_burst_reader;

    localparam int PTR   = 4;
    localparam int W     = 32;
    localparam int BL    = 4;
    localparam int TMO   = 64;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_empty;
    logic [PTR:0]  fifo_data_avail;
    logic [W-1:0]  fifo_read_data = '0;
    logic          fifo_read_en;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_last;

    always #5 clk = ~clk;

    fifo_burst_reader #(
        .FIFO_PTR   (PTR),
        .FIFO_WIDTH (W),
        .BURST_LEN  (BL),
        .TIMEOUT    (TMO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .fifo_empty      (fifo_empty),
        .fifo_data_avail (fifo_data_avail),
        .fifo_read_data  (fifo_read_data),
        .fifo_read_en    (fifo_read_en),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_last        (out_last)
    );

    // Behavioural synch_fifo: registered read data one cycle after a pop.
    logic [W-1:0]   fmem [DEPTH];
    logic [PTR:0]   fcnt;
    logic [PTR-1:0] fwp, frp;
    logic           tb_wr;
    logic [W-1:0]   tb_wdat;
    logic           fpop;

    assign fifo_empty      = (fcnt == '0);
    assign fifo_data_avail = fcnt;
    assign fpop            = fifo_read_en && !fifo_empty;

    always @(posedge clk) begin
        if (rst) begin
            fcnt <= '0;
            fwp  <= '0;
            frp  <= '0;
        end else begin
            if (tb_wr) begin
                fmem[fwp] <= tb_wdat;
                fwp       <= fwp + 1'b1;
            end
            if (fpop) begin
                fifo_read_data <= fmem[frp];
                frp            <= frp + 1'b1;
            end
            fcnt <= fcnt + (PTR+1)'(tb_wr) - (PTR+1)'(fpop);
        end
    end

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        int           n;
        logic [W-1:0] base;
        int           mode;
        int           exp_lasts;
        bit           span;
    } vec_t;
    vec_t vecs[4];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int hs_cnt, last_cnt, rd_cnt;
    int first_rd_cyc, last_rd_cyc, first_hs_cyc, last_hs_cyc;
    int issued_tot, hs_tot;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: scoreboard on handshakes, underflow, skid occupancy and stall stability.
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_d;
    logic         prev_l;
    always @(negedge clk) begin
        logic hs;
        exp_t e;
        if (rst) begin
            prev_stall = 1'b0;
            issued_tot = 0;
            hs_tot     = 0;
        end else begin
            hs = out_valid && out_ready;
            if (fifo_read_en) begin
                chk("rd_en_while_empty", fifo_empty, 0);
                chk("skid_occupancy", (issued_tot - hs_tot - (hs ? 1 : 0)) < 2, 1);
                issued_tot++;
                rd_cnt++;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                last_rd_cyc = cyc;
            end
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev_d);
                chk("stall_last", out_last, prev_l);
            end
            if (hs) begin
                chk("sb_nonempty", sbq.size() != 0, 1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    chk("beat_data", out_data, e.d);
                    chk("beat_last", out_last, e.l);
                end
                hs_tot++;
                hs_cnt++;
                if (out_last) last_cnt++;
                if (first_hs_cyc < 0) first_hs_cyc = cyc;
                last_hs_cyc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
            prev_l     = out_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        hs_cnt       = 0;
        last_cnt     = 0;
        rd_cnt       = 0;
        first_rd_cyc = -1;
        last_rd_cyc  = -1;
        first_hs_cyc = -1;
        last_hs_cyc  = -1;
    endtask

    task automatic do_reset(input int n);
        rst   = 1'b1;
        tb_wr = 1'b0;
        repeat (n) tick();
        rst = 1'b0;
        sbq.delete();
    endtask

    function automatic logic ready_for(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return (k % 2) == 0;
            2:       return k >= 20;
            default: return 1'($urandom_range(1, 0));
        endcase
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int idx = 0;
        clear_stats();
        for (int k = 0; k < 3000; k++) begin
            out_ready = ready_for(v.mode, k);
            tb_wr     = 1'b0;
            if (idx < v.n && fcnt < DEPTH) begin
                tb_wr   = 1'b1;
                tb_wdat = v.base + W'(idx);
                sbq.push_back('{d: v.base + W'(idx), l: (idx % BL) == BL - 1});
                idx++;
            end
            tick();
            if (idx == v.n && sbq.size() == 0 && fcnt == 0) break;
        end
        tb_wr = 1'b0;
        repeat (3) tick();
        chk({tag, "_drained"}, sbq.size(), 0);
        chk({tag, "_beats"}, hs_cnt, v.n);
        chk({tag, "_lasts"}, last_cnt, v.exp_lasts);
        chk({tag, "_reads"}, rd_cnt, v.n);
        if (v.span) begin
            chk({tag, "_rd_consecutive"}, last_rd_cyc - first_rd_cyc, v.n - 1);
            chk({tag, "_beat_consecutive"}, last_hs_cyc - first_hs_cyc, v.n - 1);
        end
    endtask

    initial begin
        int c0;
        vec_t clean;

        vecs[0] = '{4,  32'hA0, 0, 1, 1'b1};
        vecs[1] = '{8,  32'hB0, 1, 2, 1'b0};
        vecs[2] = '{16, 32'hC0, 2, 4, 1'b0};
        vecs[3] = '{12, 32'hD0, 3, 3, 1'b0};

        out_ready = 1'b0;
        tb_wdat   = '0;
        clear_stats();
        do_reset(3);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_rd_en", fifo_read_en, 0);
        tick();

        for (int t = 0; t < 4; t++) begin
            run_vec(vecs[t], $sformatf("vec%0d", t));
        end

        // Partial burst of three words.
        clear_stats();
        out_ready = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 3; i++) begin
            tb_wr   = 1'b1;
            tb_wdat = 32'h50 + W'(i);
            sbq.push_back('{d: 32'h50 + W'(i), l: i == 2});
            tick();
        end
        tb_wr = 1'b0;
`ifdef FIFO_BURST_READER_TIMEOUT_EN
        for (int k = 0; k < 300 && sbq.size() != 0; k++) tick();
        repeat (3) tick();
        chk("tmo_start_delay", first_rd_cyc - c0, TMO + 1);
        chk("tmo_beats", hs_cnt, 3);
        chk("tmo_lasts", last_cnt, 1);
        chk("tmo_drained", sbq.size(), 0);
`else
        repeat (150) tick();
        chk("notmo_reads", rd_cnt, 0);
        chk("notmo_beats", hs_cnt, 0);
        chk("notmo_fifo_held", fcnt, 3);
        do_reset(1);
`endif

        // Reset after the second beat of a burst.
        clear_stats();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tb_wr   = 1'b1;
            tb_wdat = 32'hE0 + W'(i);
            sbq.push_back('{d: 32'hE0 + W'(i), l: i == 3});
            tick();
            if (hs_cnt >= 2) break;
        end
        tb_wr = 1'b0;
        for (int k = 0; k < 100 && hs_cnt < 2; k++) tick();
        chk("rst_mid_beats_before", hs_cnt, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sbq.delete();
        @(negedge clk);
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_out_last", out_last, 0);
        chk("rst_mid_out_data", out_data, 0);
        chk("rst_mid_rd_en", fifo_read_en, 0);
        tick();
        repeat (10) tick();
        chk("rst_mid_no_stray_beat", hs_cnt, 2);
        clean = '{4, 32'hF0, 0, 1, 1'b1};
        run_vec(clean, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
